ip_access_ctrl: RTL and testbench
=================================

Name: ip_access_ctrl

Overview:
- Sequencer between the CPU pipeline and the memory-mapped IP core.
- Executes LWIP (opcode 6'b111111, load from IP) and SWIP (opcode 6'b111110, store to IP) as multi-cycle req/ack transactions.
- Stalls the pipeline until the IP acknowledges, then returns load data with a one-cycle valid strobe.
- Sits beside the opcode decoder; consumes the same opcode field plus the 5-bit IP select.

Parameters:
- DATA_W, 32, width of the IP read and write data buses
- SEL_W, 5, width of the IP select field
- TO_CYC, 16, cycles in REQ without ack before timeout (only used with the optional feature; must be >= 2)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous reset, active-low
- op_valid  in  1  the instruction in the decode stage is valid
- opcode  in  6  instruction opcode
- ip_sel_in  in  SEL_W  IP select from the instruction
- wdata  in  DATA_W  store data (SWIP)
- stall  out  1  holds the CPU pipeline
- ip_req  out  1  transaction request to the IP
- ip_we  out  1  1 = write (SWIP), 0 = read (LWIP)
- ip_sel  out  SEL_W  latched IP select
- ip_wdata  out  DATA_W  latched store data
- ip_ack  in  1  single-cycle acknowledge from the IP
- ip_rdata  in  DATA_W  IP read data, valid when ip_ack is high
- rdata  out  DATA_W  captured load data
- rdata_valid  out  1  1-cycle strobe: rdata is ready for register writeback
- err  out  1  sticky timeout flag
- err_clr  in  1  clears err

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE. stall, ip_req, ip_we, rdata_valid and err = 0. ip_sel, ip_wdata and rdata = 0. Timeout counter = 0.
- States: IDLE, REQ, DONE.
- IDLE:
  - Issue condition: op_valid=1 and opcode is LWIP or SWIP.
  - On issue: latch ip_sel, ip_we and ip_wdata; next state REQ.
  - stall is combinational: stall = issue condition, so the pipeline freezes in the issue cycle.
  - Any other opcode: stay in IDLE, stall=0.
- REQ:
  - ip_req=1 and stall=1. Latched outputs stay stable.
  - On ip_ack=1: if ip_we=0, capture ip_rdata into rdata. Next state DONE.
  - An ack in the first REQ cycle is legal.
  - ip_ack while in IDLE or DONE is ignored.
- DONE (exactly 1 cycle):
  - ip_req=0, stall=0, rdata_valid=1 only for a load. Next state IDLE.
  - op_valid/opcode seen during DONE belong to the retiring instruction and are not re-issued.
- Latency: issue cycle T -> REQ at T+1 -> with ack at T+1, DONE at T+2. Minimum stall is 2 cycles (T and T+1). Each extra wait cycle adds 1.
- rdata holds its value until the next load completes. ip_sel and ip_wdata hold until the next issue.
- ip_req is never asserted for two back-to-back transactions; at least 1 deasserted cycle (DONE) separates them.
- err_clr=1 clears err in any state. If a set event and err_clr occur in the same cycle, the set wins.
- Reset mid-transaction: ip_req drops immediately. Any later ip_ack is ignored while in IDLE.

Optional Feature:
- Macro: IP_TIMEOUT_EN.
- Defined:
  - A counter of width clog2(TO_CYC) clears on entry to REQ and increments each REQ cycle without ack.
  - If the count reaches TO_CYC-1 with ip_ack=0: ip_req drops, state goes to DONE, err is set.
  - For a timed-out load, rdata = 0 and rdata_valid still pulses, so the pipeline never hangs.
  - An ack arriving in the same cycle as the limit counts as success (no error).
- Undefined: no counter; REQ waits indefinitely; err is tied 0 and err_clr is unused.

Test Plan:
- LWIP, sel=5'd3, ack 1 cycle after REQ entry with ip_rdata=32'hA5A5_0001 -> ip_req high for 2 cycles, ip_we=0, ip_sel=3, stall high for 3 cycles, rdata=32'hA5A5_0001, rdata_valid pulses once in DONE.
- SWIP, sel=5'd7, wdata=32'h1234_5678, ack in the first REQ cycle -> ip_we=1, ip_wdata=32'h1234_5678, stall high for exactly 2 cycles, rdata_valid stays 0, rdata unchanged.
- Back-to-back LWIP then SWIP, immediate acks -> ip_req has a 1-cycle gap (DONE) between them; the second transaction's ip_sel and ip_wdata are correct; no double issue.
- Non-IP opcode 6'b000000 with op_valid=1, plus a stray ip_ack in IDLE -> stall=0, ip_req=0, no state change.
- rst low in the 2nd REQ cycle of an LWIP -> ip_req and stall drop asynchronously. After release: IDLE, and an ack is ignored.
- With IP_TIMEOUT_EN, TO_CYC=16, LWIP with no ack -> ip_req high for 16 cycles, then DONE with err=1, rdata=0 and rdata_valid pulsed. err_clr=1 then clears err to 0.

Source files
------------

// File: rtl/ip_access_ctrl.sv
// ip_access_ctrl: LWIP/SWIP req/ack sequencer between the CPU pipeline and the IP core
// Optional request timeout is enabled by defining IP_TIMEOUT_EN.
module ip_access_ctrl #(
    parameter int DATA_W = 32,
    parameter int SEL_W  = 5,
    parameter int TO_CYC = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              op_valid,
    input  logic [5:0]        opcode,
    input  logic [SEL_W-1:0]  ip_sel_in,
    input  logic [DATA_W-1:0] wdata,
    output logic              stall,
    output logic              ip_req,
    output logic              ip_we,
    output logic [SEL_W-1:0]  ip_sel,
    output logic [DATA_W-1:0] ip_wdata,
    input  logic              ip_ack,
    input  logic [DATA_W-1:0] ip_rdata,
    output logic [DATA_W-1:0] rdata,
    output logic              rdata_valid,
    output logic              err,
    input  logic              err_clr
);
    localparam logic [5:0] LWIP = 6'b111111;
    localparam logic [5:0] SWIP = 6'b111110;
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0] state;
    logic       issue;
    logic       to_hit;

    assign issue       = state == IDLE && op_valid && (opcode == LWIP || opcode == SWIP);
    assign stall       = issue || state == REQ;
    assign ip_req      = state == REQ;
    assign rdata_valid = state == DONE && !ip_we;

`ifdef IP_TIMEOUT_EN
    localparam int CW = $clog2(TO_CYC);
    logic [CW-1:0] cnt;

    assign to_hit = state == REQ && !ip_ack && cnt == CW'(TO_CYC - 1);

    // Wait counter: runs only while REQ is unanswered, zero everywhere else
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt <= '0;
        else      cnt <= (state == REQ && !ip_ack && !to_hit) ? cnt + 1'b1 : '0;
    end

    // Sticky timeout flag; a new timeout beats a simultaneous clear
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) err <= 1'b0;
        else      err <= to_hit ? 1'b1 : err_clr ? 1'b0 : err;
    end
`else
    logic unused_err_clr;
    assign to_hit         = 1'b0;
    assign err            = 1'b0;
    assign unused_err_clr = err_clr & (TO_CYC > 1);
`endif

    // Transaction sequencer: latch on issue, wait for ack (or timeout), one DONE cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            ip_we    <= 1'b0;
            ip_sel   <= '0;
            ip_wdata <= '0;
            rdata    <= '0;
        end else if (issue) begin
            state    <= REQ;
            ip_we    <= opcode == SWIP;
            ip_sel   <= ip_sel_in;
            ip_wdata <= wdata;
        end else if (state == REQ) begin
            if (ip_ack || to_hit) begin
                state <= DONE;
                if (!ip_we) rdata <= ip_ack ? ip_rdata : '0;
            end
        end else begin
            state <= IDLE;
        end
    end
endmodule

// File: tb/tb_ip_access_ctrl.sv
// tb_ip_access_ctrl: randomized self-checking bench for ip_access_ctrl
module tb_ip_access_ctrl;
    localparam logic [5:0] LWIP = 6'b111111;
    localparam logic [5:0] SWIP = 6'b111110;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        op_valid = 1'b0;
    logic [5:0]  opcode = '0;
    logic [4:0]  ip_sel_in = '0;
    logic [31:0] wdata = '0;
    logic        stall, ip_req, ip_we, rdata_valid, err;
    logic [4:0]  ip_sel;
    logic [31:0] ip_wdata, rdata;
    logic        ip_ack = 1'b0;
    logic [31:0] ip_rdata = '0;
    logic        err_clr = 1'b0;

    int n_checks = 0;
    int n_fail = 0;
    logic [31:0] rdata_m = '0;

    ip_access_ctrl dut (
        .clk(clk), .rst(rst), .op_valid(op_valid), .opcode(opcode),
        .ip_sel_in(ip_sel_in), .wdata(wdata), .stall(stall), .ip_req(ip_req),
        .ip_we(ip_we), .ip_sel(ip_sel), .ip_wdata(ip_wdata), .ip_ack(ip_ack),
        .ip_rdata(ip_rdata), .rdata(rdata), .rdata_valid(rdata_valid),
        .err(err), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    // One complete transaction: issue, wt wait cycles, ack, DONE
    task automatic run_txn(input logic load, input logic [4:0] sel, input logic [31:0] wd,
                           input int wt, input logic [31:0] rd);
        int st_n;
        int rq_n;
        @(negedge clk);
        op_valid = 1'b1; opcode = load ? LWIP : SWIP; ip_sel_in = sel; wdata = wd; ip_ack = 1'b0;
        #1;
        st_n = int'(stall);
        rq_n = 0;
        n_checks++;
        if (ip_req !== 1'b0) begin n_fail++; $display("FAIL issue_req: got %b want 0", ip_req); end
        @(posedge clk);
        for (int k = 0; k <= wt; k++) begin
            @(negedge clk);
            ip_ack = (k == wt);
            ip_rdata = (k == wt) ? rd : $urandom;
            ip_sel_in = 5'($urandom);
            wdata = $urandom;
            #1;
            st_n += int'(stall);
            rq_n += int'(ip_req);
            n_checks++;
            if (ip_sel !== sel || ip_we !== !load || ip_wdata !== wd) begin
                n_fail++;
                $display("FAIL req_latch: got sel=%0d we=%b wd=%h want sel=%0d we=%b wd=%h",
                         ip_sel, ip_we, ip_wdata, sel, !load, wd);
            end
            @(posedge clk);
        end
        @(negedge clk);
        ip_ack = 1'b0;
        #1;
        st_n += int'(stall);
        if (load) rdata_m = rd;
        n_checks++;
        if (ip_req !== 1'b0 || rdata_valid !== load || err !== 1'b0) begin
            n_fail++;
            $display("FAIL done_state: got req=%b rv=%b err=%b want req=0 rv=%b err=0",
                     ip_req, rdata_valid, err, load);
        end
        n_checks++;
        if (rdata !== rdata_m) begin n_fail++; $display("FAIL done_rdata: got %h want %h", rdata, rdata_m); end
        n_checks++;
        if (st_n != wt + 2 || rq_n != wt + 1) begin
            n_fail++;
            $display("FAIL txn_len: got stall=%0d req=%0d want stall=%0d req=%0d", st_n, rq_n, wt + 2, wt + 1);
        end
        @(posedge clk);
    endtask

    task automatic go_idle();
        @(negedge clk);
        op_valid = 1'b0; opcode = '0; ip_ack = 1'b0;
        #1;
        n_checks++;
        if (stall !== 1'b0 || ip_req !== 1'b0 || rdata_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL idle: got stall=%b req=%b rv=%b want 0 0 0", stall, ip_req, rdata_valid);
        end
    endtask

    task automatic test_reset();
        #1;
        n_checks++;
        if ({stall, ip_req, ip_we, rdata_valid, err} !== 5'b0 || ip_sel !== '0 || ip_wdata !== '0 || rdata !== '0) begin
            n_fail++;
            $display("FAIL reset: got st=%b rq=%b we=%b rv=%b err=%b sel=%0d wd=%h rd=%h want all 0",
                     stall, ip_req, ip_we, rdata_valid, err, ip_sel, ip_wdata, rdata);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_plan_cases();
        run_txn(1'b1, 5'd3, 32'h0, 1, 32'hA5A5_0001);
        go_idle();
        run_txn(1'b0, 5'd7, 32'h1234_5678, 0, 32'hFFFF_FFFF);
        go_idle();
    endtask

    task automatic test_back_to_back();
        run_txn(1'b1, 5'd12, 32'h0BAD_F00D, 0, 32'hCAFE_0002);
        run_txn(1'b0, 5'd21, 32'h8765_4321, 0, 32'h1111_2222);
        go_idle();
    endtask

    task automatic test_non_ip();
        @(negedge clk);
        op_valid = 1'b1; opcode = 6'b000000; ip_ack = 1'b1; ip_rdata = 32'hDEAD_BEEF;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_checks++;
            if (stall !== 1'b0 || ip_req !== 1'b0 || rdata_valid !== 1'b0 || rdata !== rdata_m) begin
                n_fail++;
                $display("FAIL non_ip: got st=%b rq=%b rv=%b rd=%h want 0 0 0 %h",
                         stall, ip_req, rdata_valid, rdata, rdata_m);
            end
            @(negedge clk);
        end
        ip_ack = 1'b0;
        go_idle();
    endtask

    task automatic test_random();
        for (int i = 0; i < 25; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(negedge clk);
                op_valid = 1'($urandom);
                opcode = 6'($urandom_range(0, 61));
                ip_ack = 1'($urandom);
                #1;
                n_checks++;
                if (stall !== 1'b0 || ip_req !== 1'b0) begin
                    n_fail++;
                    $display("FAIL rand_nonip: op=%b got st=%b rq=%b want 0 0", opcode, stall, ip_req);
                end
                ip_ack = 1'b0;
            end else begin
                run_txn(1'($urandom), 5'($urandom), $urandom, $urandom_range(0, 3), $urandom);
            end
        end
        go_idle();
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        op_valid = 1'b1; opcode = LWIP; ip_sel_in = 5'd9; ip_ack = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        n_checks++;
        if (ip_req !== 1'b1) begin n_fail++; $display("FAIL mid_req: got %b want 1", ip_req); end
        rst = 1'b0; op_valid = 1'b0;
        #1;
        rdata_m = '0;
        n_checks++;
        if (ip_req !== 1'b0 || stall !== 1'b0 || rdata !== '0 || ip_sel !== '0) begin
            n_fail++;
            $display("FAIL mid_rst: got rq=%b st=%b rd=%h sel=%0d want 0 0 0 0", ip_req, stall, rdata, ip_sel);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        ip_ack = 1'b1; ip_rdata = 32'hDEAD_0003;
        #1;
        n_checks++;
        if (ip_req !== 1'b0 || stall !== 1'b0) begin
            n_fail++;
            $display("FAIL post_rst_ack: got rq=%b st=%b want 0 0", ip_req, stall);
        end
        @(negedge clk);
        ip_ack = 1'b0;
        #1;
        n_checks++;
        if (rdata_valid !== 1'b0 || rdata !== '0 || ip_req !== 1'b0) begin
            n_fail++;
            $display("FAIL post_rst_idle: got rv=%b rd=%h rq=%b want 0 0 0", rdata_valid, rdata, ip_req);
        end
    endtask

`ifdef IP_TIMEOUT_EN
    task automatic test_timeout();
        int rq_n;
        @(negedge clk);
        op_valid = 1'b1; opcode = LWIP; ip_sel_in = 5'd4; ip_ack = 1'b0;
        @(posedge clk);
        rq_n = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            #1;
            if (ip_req !== 1'b1) break;
            rq_n++;
        end
        rdata_m = '0;
        n_checks++;
        if (rq_n != 16) begin n_fail++; $display("FAIL to_len: got %0d want 16", rq_n); end
        n_checks++;
        if (err !== 1'b1 || rdata_valid !== 1'b1 || rdata !== '0) begin
            n_fail++;
            $display("FAIL to_done: got err=%b rv=%b rd=%h want 1 1 0", err, rdata_valid, rdata);
        end
        @(negedge clk);
        op_valid = 1'b0;
        #1;
        n_checks++;
        if (err !== 1'b1 || ip_req !== 1'b0) begin
            n_fail++;
            $display("FAIL to_sticky: got err=%b rq=%b want 1 0", err, ip_req);
        end
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        #1;
        n_checks++;
        if (err !== 1'b0) begin n_fail++; $display("FAIL err_clr: got %b want 0", err); end
    endtask
`endif

    initial begin
        test_reset();
        test_plan_cases();
        test_back_to_back();
        test_non_ip();
        test_random();
        test_reset_mid();
`ifdef IP_TIMEOUT_EN
        test_timeout();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
